// File: rtl/wgt_shift_bank.sv
// Serial-load weight staging buffer: ROWS x K signed taps, one row per read.
// Optional second (active) bank enabled by defining WGT_DBUF_EN.
module wgt_shift_bank #(
  parameter  int DATA_W = 8,
  parameter  int K      = 3,
  parameter  int ROWS   = 3,
  localparam int N      = ROWS * K,
  localparam int CW     = $clog2(N + 1),
  localparam int RW     = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic signed [DATA_W-1:0] wgt_in,
  input  logic                     wgt_valid,
  output logic                     wgt_ready,
  input  logic                     wgt_clear,
  input  logic                     wgt_swap,
  output logic [CW-1:0]            fill_cnt,
  output logic                     wgt_full,
  input  logic                     rd_en,
  input  logic [RW-1:0]            rd_row,
  output logic [K*DATA_W-1:0]      rd_data,
  output logic                     rd_valid
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] NFULL = CW'(N);

  logic [DATA_W-1:0]   ld_q [N];
  logic [DATA_W-1:0]   ld_d [N];
  logic [DATA_W-1:0]   act  [N];
  logic [CW-1:0]       fill_q, fill_d;
  logic [K*DATA_W-1:0] rd_data_q, rd_data_d;
  logic                rd_valid_q;
  logic [K*DATA_W-1:0] row_data;
  logic                accept;
  logic                swap_ok;
  logic                is_full_set;

  assign is_full_set = (fill_q == NFULL);
  assign wgt_ready   = !is_full_set && !wgt_clear;
  assign accept      = wgt_valid && wgt_ready;
  assign fill_cnt    = fill_q;

  always_comb begin
    ld_d = ld_q;
    if (accept) begin
      ld_d[0] = wgt_in;
      for (int i = 1; i < N; i++) begin
        ld_d[i] = ld_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        ld_q[i] <= '0;
      end
    end else begin
      ld_q <= ld_d;
    end
  end

  // Clear outranks swap; accept cannot coincide with either.
  always_comb begin
    fill_d = fill_q;
    if (wgt_clear) begin
      fill_d = '0;
    end else if (swap_ok) begin
      fill_d = '0;
    end else if (accept) begin
      fill_d = fill_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fill_q <= '0;
    end else begin
      fill_q <= fill_d;
    end
  end

`ifdef WGT_DBUF_EN
  logic [DATA_W-1:0] act_q [N];
  logic              full_q;

  assign swap_ok  = wgt_swap && is_full_set && !wgt_clear;
  assign act      = act_q;
  assign wgt_full = full_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        act_q[i] <= '0;
      end
      full_q <= 1'b0;
    end else if (swap_ok) begin
      act_q  <= ld_q;
      full_q <= 1'b1;
    end
  end
`else
  logic unused_swap;

  assign unused_swap = wgt_swap;
  assign swap_ok     = 1'b0;
  assign act         = ld_q;
  assign wgt_full    = is_full_set;
`endif

  always_comb begin
    row_data = '0;
    if (int'(rd_row) < ROWS) begin
      for (int t = 0; t < K; t++) begin
        row_data[t*DATA_W +: DATA_W] =
          act[IW'(int'(rd_row) * K + t)];
      end
    end
  end

  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) begin
      rd_data_d = row_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_en;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_wgt_shift_bank.sv
// Directed bench for wgt_shift_bank (default single-bank build).
// Inputs change 1ns after the rising edge; outputs are checked there too.
module tb_wgt_shift_bank;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  wgt_in;
  logic        wgt_valid;
  logic        wgt_ready;
  logic        wgt_clear;
  logic        wgt_swap;
  logic [3:0]  fill_cnt;
  logic        wgt_full;
  logic        rd_en;
  logic [1:0]  rd_row;
  logic [23:0] rd_data;
  logic        rd_valid;

  int checks   = 0;
  int failures = 0;

  wgt_shift_bank #(
    .DATA_W(8),
    .K(3),
    .ROWS(3)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .wgt_in(wgt_in),
    .wgt_valid(wgt_valid),
    .wgt_ready(wgt_ready),
    .wgt_clear(wgt_clear),
    .wgt_swap(wgt_swap),
    .fill_cnt(fill_cnt),
    .wgt_full(wgt_full),
    .rd_en(rd_en),
    .rd_row(rd_row),
    .rd_data(rd_data),
    .rd_valid(rd_valid)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    wgt_in = '0;
    wgt_valid = 1'b0;
    wgt_clear = 1'b0;
    wgt_swap = 1'b0;
    rd_en = 1'b0;
    rd_row = '0;
    tick();
    tick();
    chk("rst_fill", 64'(fill_cnt), 64'd0);
    chk("rst_full", 64'(wgt_full), 64'd0);
    chk("rst_rdv", 64'(rd_valid), 64'd0);
    chk("rst_rdd", 64'(rd_data), 64'd0);
    rst_n = 1'b1;
    #1;
    chk("rst_ready", 64'(wgt_ready), 64'd1);

    // Stream 1..9; full rises after the 9th accept.
    for (int i = 1; i <= 9; i++) begin
      wgt_valid = 1'b1;
      wgt_in = 8'(i);
      tick();
      if (i == 5) chk("fill5", 64'(fill_cnt), 64'd5);
      if (i == 8) chk("full_at8", 64'(wgt_full), 64'd0);
    end
    wgt_valid = 1'b0;
    chk("fill9", 64'(fill_cnt), 64'd9);
    chk("full9", 64'(wgt_full), 64'd1);
    chk("ready9", 64'(wgt_ready), 64'd0);

    // Out-of-range row, then rows 0,1,2 back to back.
    rd_en = 1'b1;
    rd_row = 2'd3;
    tick();
    chk("row3_v", 64'(rd_valid), 64'd1);
    chk("row3_d", 64'(rd_data), 64'h0);
    rd_row = 2'd0;
    tick();
    chk("row0_v", 64'(rd_valid), 64'd1);
    chk("row0_d", 64'(rd_data), 64'h070809);
    rd_row = 2'd1;
    tick();
    chk("row1_v", 64'(rd_valid), 64'd1);
    chk("row1_d", 64'(rd_data), 64'h040506);
    rd_row = 2'd2;
    tick();
    chk("row2_v", 64'(rd_valid), 64'd1);
    chk("row2_d", 64'(rd_data), 64'h010203);
    rd_en = 1'b0;
    rd_row = 2'd0;
    tick();
    chk("idle_v", 64'(rd_valid), 64'd0);
    chk("idle_hold", 64'(rd_data), 64'h010203);

    // Full buffer stalls a held-valid producer.
    wgt_valid = 1'b1;
    wgt_in = 8'h55;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_rdy", 64'(wgt_ready), 64'd0);
    end
    chk("stall_fill", 64'(fill_cnt), 64'd9);
    wgt_valid = 1'b0;
    rd_en = 1'b1;
    rd_row = 2'd0;
    tick();
    rd_en = 1'b0;
    chk("stall_row0", 64'(rd_data), 64'h070809);

    // Swap has no effect in the single-bank build.
    wgt_swap = 1'b1;
    tick();
    wgt_swap = 1'b0;
    chk("swap_fill", 64'(fill_cnt), 64'd9);

    // Clear, load 4, clear together with valid.
    wgt_clear = 1'b1;
    tick();
    wgt_clear = 1'b0;
    chk("clr_fill", 64'(fill_cnt), 64'd0);
    chk("clr_full", 64'(wgt_full), 64'd0);
    for (int i = 0; i < 4; i++) begin
      wgt_valid = 1'b1;
      wgt_in = 8'(8'h11 + i);
      tick();
    end
    chk("fill4", 64'(fill_cnt), 64'd4);
    wgt_clear = 1'b1;
    wgt_in = 8'h99;
    #1;
    chk("clr_rdy", 64'(wgt_ready), 64'd0);
    tick();
    wgt_clear = 1'b0;
    chk("clr4_fill", 64'(fill_cnt), 64'd0);
    for (int i = 0; i < 9; i++) begin
      wgt_in = 8'(8'h21 + i);
      tick();
    end
    wgt_valid = 1'b0;
    chk("rl_fill", 64'(fill_cnt), 64'd9);
    rd_en = 1'b1;
    rd_row = 2'd0;
    tick();
    chk("rl_row0", 64'(rd_data), 64'h272829);
    rd_row = 2'd2;
    tick();
    chk("rl_row2", 64'(rd_data), 64'h212223);
    rd_en = 1'b0;

    // Clear keeps contents; read alongside an accept sees old data.
    wgt_clear = 1'b1;
    tick();
    wgt_clear = 1'b0;
    wgt_valid = 1'b1;
    wgt_in = 8'h5A;
    rd_en = 1'b1;
    rd_row = 2'd0;
    tick();
    wgt_valid = 1'b0;
    chk("rdacc_old", 64'(rd_data), 64'h272829);
    tick();
    rd_en = 1'b0;
    chk("rdacc_new", 64'(rd_data), 64'h28295A);
    chk("rdacc_fill", 64'(fill_cnt), 64'd1);

    // Reset after 5 accepts discards everything.
    wgt_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wgt_in = 8'(8'h61 + i);
      tick();
    end
    wgt_valid = 1'b0;
    chk("pre_rst_fill", 64'(fill_cnt), 64'd5);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mrst_fill", 64'(fill_cnt), 64'd0);
    chk("mrst_full", 64'(wgt_full), 64'd0);
    chk("mrst_rdv", 64'(rd_valid), 64'd0);
    chk("mrst_rdd", 64'(rd_data), 64'd0);
    rd_en = 1'b1;
    for (int r = 0; r < 3; r++) begin
      rd_row = 2'(r);
      tick();
      chk("mrst_row", 64'(rd_data), 64'd0);
    end
    rd_en = 1'b0;

    // Negative weights pass through unmodified.
    wgt_valid = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      wgt_in = 8'(-i);
      tick();
    end
    wgt_valid = 1'b0;
    rd_en = 1'b1;
    rd_row = 2'd0;
    tick();
    chk("neg_row0", 64'(rd_data), 64'hF9F8F7);
    rd_row = 2'd2;
    tick();
    rd_en = 1'b0;
    chk("neg_row2", 64'(rd_data), 64'hFFFEFD);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
